// File: rtl/pc_gen.sv
// Fetch PC generator: one PC per cycle over valid/ready, prioritised redirects,
// and a direct-mapped BTB with 2-bit counters trained from EX.
module pc_gen #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VEC   = WIDTH'(32'h80000000),
  parameter int               BTB_ENTRIES = 8
) (
  input  logic             clk,
  input  logic             rst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic             out_pred_taken,
  output logic [WIDTH-1:0] out_pred_target,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] mtvec,
  input  logic             mret_valid,
  input  logic [WIDTH-1:0] mepc,
  input  logic             ex_redirect,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             upd_valid,
  input  logic [WIDTH-1:0] upd_pc,
  input  logic             upd_taken,
  input  logic [WIDTH-1:0] upd_target
);

  localparam int IDXW = $clog2(BTB_ENTRIES);
  localparam int TAGW = WIDTH - IDXW - 2;

  // state   | meaning
  // BOOT    | first cycle after reset release, no fetch request
  // RUN     | presenting fetch PCs every cycle
  typedef enum logic {ST_BOOT, ST_RUN} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;

  logic [BTB_ENTRIES-1:0] valid_q;
  logic [TAGW-1:0]        tag_q    [BTB_ENTRIES];
  logic [1:0]             ctr_q    [BTB_ENTRIES];
  logic [WIDTH-1:0]       target_q [BTB_ENTRIES];

  logic [IDXW-1:0] lk_idx, up_idx;
  logic [TAGW-1:0] lk_tag, up_tag;
  logic            lk_hit, up_hit;
  logic [1:0]      up_ctr, up_ctr_nxt;

  // Low address bits of incoming PCs are forced to zero, so they are never read.
  logic unused_lsbs;
  assign unused_lsbs = ^{mtvec[1:0], mepc[1:0], ex_target[1:0], upd_target[1:0], upd_pc[1:0]};

  // Lookup reads only registered state, so prediction timing is fixed by pc_q.
  assign lk_idx = pc_q[IDXW+1:2];
  assign lk_tag = pc_q[WIDTH-1:IDXW+2];
  assign lk_hit = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);

  assign out_pc          = pc_q;
  assign out_pred_taken  = lk_hit && ctr_q[lk_idx][1];
  assign out_pred_target = out_pred_taken ? target_q[lk_idx] : pc_q + WIDTH'(4);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    out_valid = 1'b0;
    case (state_q)
      ST_BOOT: begin
        state_d = ST_RUN;
        pc_d    = RESET_VEC;
      end
      ST_RUN: begin
        out_valid = 1'b1;
        if (trap_valid)       pc_d = {mtvec[WIDTH-1:2], 2'b00};
        else if (mret_valid)  pc_d = {mepc[WIDTH-1:2], 2'b00};
        else if (ex_redirect) pc_d = {ex_target[WIDTH-1:2], 2'b00};
        else if (out_ready)   pc_d = out_pred_target;
      end
      default: begin
        state_d = ST_BOOT;
        pc_d    = RESET_VEC;
      end
    endcase
  end

  assign up_idx = upd_pc[IDXW+1:2];
  assign up_tag = upd_pc[WIDTH-1:IDXW+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
  assign up_ctr = ctr_q[up_idx];

  always_comb begin
    up_ctr_nxt = up_ctr;
    if (upd_taken) begin
      if (up_ctr != 2'd3) up_ctr_nxt = up_ctr + 2'd1;
    end else begin
      if (up_ctr != 2'd0) up_ctr_nxt = up_ctr - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (upd_valid && !up_hit && upd_taken) begin
      valid_q[up_idx] <= 1'b1;
    end
  end

  // Payload arrays carry no reset; the rst gate keeps a write from landing
  // on an edge where reset is held.
  always_ff @(posedge clk) begin
    if (upd_valid && !rst) begin
      if (up_hit) begin
        ctr_q[up_idx] <= up_ctr_nxt;
        if (upd_taken) target_q[up_idx] <= {upd_target[WIDTH-1:2], 2'b00};
      end else if (upd_taken) begin
        tag_q[up_idx]    <= up_tag;
        ctr_q[up_idx]    <= 2'b10;
        target_q[up_idx] <= {upd_target[WIDTH-1:2], 2'b00};
      end
    end
  end

endmodule
